// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the FIFO blocks in this codebase.
package fifo_pkg;

    localparam int FIFO_DEF_IN_BITS    = 8;
    localparam int FIFO_DEF_RATIO      = 4;
    localparam int FIFO_DEF_DEPTH_LOG2 = 2;

    // Smallest r such that 2**r >= value; used for lane and pointer widths.
    function automatic int fifo_log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// Assembles RATIO narrow lanes into one wide word and decides when the
// word is committed to storage (word complete, or flushed partial word).
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int IN_BITS = FIFO_DEF_IN_BITS,
    parameter int RATIO   = FIFO_DEF_RATIO,
    localparam int LW       = fifo_log2(RATIO),
    localparam int OUT_BITS = IN_BITS * RATIO
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IN_BITS-1:0]  data_i,
    input  logic                wr_en_i,
    input  logic                flush_i,
    input  logic                full_i,
    output logic                commit_o,
    output logic [OUT_BITS-1:0] word_o,
    output logic [LW-1:0]       lane_count_o
);

    logic [LW-1:0]       lane_q, lane_d;
    logic [OUT_BITS-1:0] asm_q, asm_d;
    logic [OUT_BITS-1:0] merged;
    logic                wr_acc;
    logic                held;
    logic                commit;

    // Merge the incoming lane and decide on a commit. The assembler is
    // cleared after every commit, so unfilled lanes of a flushed word are zero.
    always_comb begin
        wr_acc = wr_en_i && !full_i;
        merged = asm_q;
        if (wr_acc) begin
            merged[lane_q*IN_BITS +: IN_BITS] = data_i;
        end
        held   = (lane_q != '0) || wr_acc;
        commit = (wr_acc && (lane_q == LW'(RATIO - 1))) ||
                 (flush_i && !full_i && held);
        lane_d = lane_q;
        asm_d  = asm_q;
        if (commit) begin
            lane_d = '0;
            asm_d  = '0;
        end else if (wr_acc) begin
            lane_d = lane_q + 1'b1;
            asm_d  = merged;
        end
    end

    // Assembler state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
            asm_q  <= '0;
        end else begin
            lane_q <= lane_d;
            asm_q  <= asm_d;
        end
    end

    assign commit_o     = commit;
    assign word_o       = merged;
    assign lane_count_o = lane_q;

endmodule

// File: rtl/width_conv_fifo.sv
// Narrow-write / wide-read FIFO: lanes are packed into words by the packer,
// stored in a small memory, and read out through a registered output.
module width_conv_fifo
    import fifo_pkg::*;
#(
    parameter int IN_BITS    = FIFO_DEF_IN_BITS,
    parameter int RATIO      = FIFO_DEF_RATIO,
    parameter int DEPTH_LOG2 = FIFO_DEF_DEPTH_LOG2,
    parameter int AF_THRESH  = (1 << DEPTH_LOG2) - 1,
    localparam int OUT_BITS = IN_BITS * RATIO,
    localparam int LW       = fifo_log2(RATIO),
    localparam int DEPTH    = 1 << DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IN_BITS-1:0]    data_in,
    input  logic                  write_en,
    input  logic                  flush,
    input  logic                  read_en,
    output logic [OUT_BITS-1:0]   data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [DEPTH_LOG2:0]   level,
    output logic [LW-1:0]         lane_count
);

    localparam logic [DEPTH_LOG2:0] DEPTH_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] AF_LEVEL    = (DEPTH_LOG2 + 1)'(AF_THRESH);

    logic [OUT_BITS-1:0]   mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [OUT_BITS-1:0]   data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  commit;
    logic [OUT_BITS-1:0]   commit_word;
    logic                  rd_acc;
    logic                  full_w;
    logic                  empty_w;

    fifo_word_packer #(
        .IN_BITS (IN_BITS),
        .RATIO   (RATIO)
    ) u_packer (
        .clk          (clk),
        .rst_n        (reset),
        .data_i       (data_in),
        .wr_en_i      (write_en),
        .flush_i      (flush),
        .full_i       (full_w),
        .commit_o     (commit),
        .word_o       (commit_word),
        .lane_count_o (lane_count)
    );

    // Status flags come from the level register alone.
    always_comb begin
        full_w      = (level_q == DEPTH_LEVEL);
        empty_w     = (level_q == '0);
        almost_full = (level_q >= AF_LEVEL);
    end

    // Pointer, level and read-register next state. A read only sees words
    // already in memory, so a word committed this cycle is readable next cycle.
    always_comb begin
        rd_acc       = read_en && !empty_w;
        wr_ptr_d     = commit ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
        data_out_d   = rd_acc ? mem[rd_ptr_q] : data_out_q;
        data_valid_d = rd_acc;
        case ({commit, rd_acc})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Control and read-data registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[wr_ptr_q] <= commit_word;
        end
    end

    assign full       = full_w;
    assign empty      = empty_w;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign level      = level_q;

endmodule

// File: tb/tb_width_conv_fifo.sv
// Scoreboard bench for width_conv_fifo with default parameters.
module tb_width_conv_fifo;

    logic        clk;
    logic        reset;
    logic [7:0]  data_in;
    logic        write_en;
    logic        flush;
    logic        read_en;
    logic [31:0] data_out;
    logic        data_valid;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic [2:0]  level;
    logic [1:0]  lane_count;

    int checks = 0;
    int passes = 0;
    logic [31:0] sb[$];
    logic [31:0] mq[$];

    width_conv_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .write_en    (write_en),
        .flush       (flush),
        .read_en     (read_en),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .level       (level),
        .lane_count  (lane_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every presented read word is compared with the oldest expectation.
    always @(negedge clk) begin
        if (reset && data_valid) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_valid: got data_out %h expected no valid", data_out);
            end else begin
                check("read_data", data_out, sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] b, input logic fl);
        write_en = 1'b1;
        data_in  = b;
        flush    = fl;
        tick();
        write_en = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic rd(input logic [31:0] exp);
        sb.push_back(exp);
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [7:0]  b;
        reset = 1'b0; data_in = '0; write_en = 0; flush = 0; read_en = 0;
        #3;
        check("rst_empty", {31'b0, empty}, 1);
        check("rst_full", {31'b0, full}, 0);
        check("rst_af", {31'b0, almost_full}, 0);
        check("rst_level", {29'b0, level}, 0);
        check("rst_dout", data_out, 0);
        #9 reset = 1'b1;
        tick();

        // Four lanes make one word; first lane lands least significant.
        wr(8'h11, 0); wr(8'h22, 0); wr(8'h33, 0);
        check("t1_level_before", {29'b0, level}, 0);
        check("t1_lane3", {30'b0, lane_count}, 3);
        wr(8'h44, 0);
        check("t1_level", {29'b0, level}, 1);
        rd(32'h44332211);
        tick(); tick();
        check("t1_dout_hold", data_out, 32'h44332211);
        check("t1_valid_low", {31'b0, data_valid}, 0);

        // Fill to full; extra writes are dropped.
        for (int i = 0; i < 16; i++) wr(8'(8'h10 + i), 0);
        check("t2_full", {31'b0, full}, 1);
        check("t2_af", {31'b0, almost_full}, 1);
        for (int i = 0; i < 4; i++) wr(8'hEE, 0);
        check("t2_lane", {30'b0, lane_count}, 0);
        check("t2_level", {29'b0, level}, 4);
        for (int k = 0; k < 4; k++) begin
            w = {8'(8'h13 + 4*k), 8'(8'h12 + 4*k), 8'(8'h11 + 4*k), 8'(8'h10 + 4*k)};
            rd(w);
        end
        check("t2_empty", {31'b0, empty}, 1);

        // Flush of a partial word, then flush together with a write.
        wr(8'hAA, 0); wr(8'hBB, 0); do_flush();
        check("t3_level", {29'b0, level}, 1);
        check("t3_lane", {30'b0, lane_count}, 0);
        rd(32'h0000BBAA);
        wr(8'hDD, 0); wr(8'hCC, 1);
        check("t3b_level", {29'b0, level}, 1);
        rd(32'h0000CCDD);
        tick();

        // Read while empty and flush with nothing held are no-ops.
        read_en = 1'b1; tick(); read_en = 1'b0;
        do_flush();
        tick();
        check("t5_level", {29'b0, level}, 0);
        check("t5_dout", data_out, 32'h0000CCDD);
        check("t5_valid", {31'b0, data_valid}, 0);

        // Streaming across pointer wrap: a read lands on each commit cycle.
        for (int i = 0; i < 8; i++) wr(8'(8'h40 + i), 0);
        mq.push_back(32'h43424140);
        mq.push_back(32'h47464544);
        check("t4_level_start", {29'b0, level}, 2);
        w = '0;
        for (int c = 0; c < 32; c++) begin
            b = 8'(8'h48 + c);
            write_en = 1'b1;
            data_in  = b;
            read_en  = (c % 4 == 3);
            if (c % 4 == 3) sb.push_back(mq.pop_front());
            w[(c%4)*8 +: 8] = b;
            if (c % 4 == 3) begin
                mq.push_back(w);
                w = '0;
            end
            tick();
            checks++;
            if (level >= 1 && level <= 3) passes++;
            else $display("FAIL t4_level_range: got %0d expected 1..3", level);
        end
        write_en = 1'b0; read_en = 1'b0;
        while (mq.size() > 0) rd(mq.pop_front());
        tick();
        check("t4_empty", {31'b0, empty}, 1);

        // Asynchronous reset between edges with lanes and words held.
        for (int i = 0; i < 11; i++) wr(8'(8'h70 + i), 0);
        check("t6_lane", {30'b0, lane_count}, 3);
        check("t6_level", {29'b0, level}, 2);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_level", {29'b0, level}, 0);
        check("t6_rst_lane", {30'b0, lane_count}, 0);
        check("t6_rst_empty", {31'b0, empty}, 1);
        check("t6_rst_full", {31'b0, full}, 0);
        check("t6_rst_dout", data_out, 0);
        check("t6_rst_valid", {31'b0, data_valid}, 0);
        #2 reset = 1'b1;
        tick();
        wr(8'h01, 0); wr(8'h02, 0); wr(8'h03, 0); wr(8'h04, 0);
        check("t6_level_after", {29'b0, level}, 1);
        rd(32'h04030201);
        tick(); tick();
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
